smm1_sequencer: RTL and testbench

SMM1_SEQUENCER -- requirements
Module: smm1_sequencer

---
 rtl/smm_pkg.sv | 21 ++
 rtl/smm1_sequencer_ctrl.sv | 115 +++++++++++
 rtl/smm1_sequencer.sv | 88 ++++++++
 tb/tb_smm1_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smm_pkg.sv
// Shared definitions for the single-matrix sequencer: state encoding, matrix
// geometry and default element width.
package smm_pkg;

  localparam int ELEMS         = 16;
  localparam int IDX_W         = 4;
  localparam int DEF_DATAWIDTH = 32;

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_FIRE   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(ELEMS - 1);
  endfunction

endpackage

// File: rtl/smm1_sequencer_ctrl.sv
// Sequencer FSM and counters: input element count, latency counter, output
// index and the captured mode bit. Handshake flags are registered from next state.
module smm1_sequencer_ctrl
  import smm_pkg::*;
#(
  parameter int LATENCY = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sel_in,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             busy,
  output logic             smm_load,
  output logic             smm_sel,
  output logic             out_valid,
  output logic             out_last,
  output logic             wr_a,
  output logic             wr_b,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] out_idx,
  output logic             capture
);

  localparam logic [7:0] WAIT_LAST = 8'(LATENCY - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] in_cnt_reg, in_cnt_next;
  logic [IDX_W-1:0] out_idx_reg, out_idx_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic             sel_reg, sel_next;
  logic             in_ready_reg, busy_reg, load_reg, out_valid_reg, out_last_reg;

  always_comb begin
    state_next    = state_reg;
    in_cnt_next   = in_cnt_reg;
    out_idx_next  = out_idx_reg;
    wait_cnt_next = wait_cnt_reg;
    sel_next      = sel_reg;
    case (state_reg)
      ST_LOAD_A: begin
        if (in_valid) begin
          if (in_cnt_reg == '0) sel_next = sel_in;
          in_cnt_next = in_cnt_reg + 1'b1;
          if (is_last_idx(in_cnt_reg)) state_next = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (in_valid) begin
          in_cnt_next = in_cnt_reg + 1'b1;
          if (is_last_idx(in_cnt_reg)) state_next = ST_FIRE;
        end
      end
      ST_FIRE: begin
        wait_cnt_next = '0;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) state_next = ST_DRAIN;
        else wait_cnt_next = wait_cnt_reg + 1'b1;
      end
      ST_DRAIN: begin
        if (out_ready) begin
          out_idx_next = out_idx_reg + 1'b1;
          if (is_last_idx(out_idx_reg)) begin
            state_next  = ST_LOAD_A;
            in_cnt_next = '0;
          end
        end
      end
      default: state_next = ST_LOAD_A;
    endcase
  end

  // Flags are decoded from the next state so they line up with state_reg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_LOAD_A;
      in_cnt_reg    <= '0;
      out_idx_reg   <= '0;
      wait_cnt_reg  <= '0;
      sel_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      load_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_cnt_reg    <= in_cnt_next;
      out_idx_reg   <= out_idx_next;
      wait_cnt_reg  <= wait_cnt_next;
      sel_reg       <= sel_next;
      in_ready_reg  <= (state_next == ST_LOAD_A) || (state_next == ST_LOAD_B);
      busy_reg      <= !((state_next == ST_LOAD_A) && (in_cnt_next == '0));
      load_reg      <= (state_next == ST_FIRE);
      out_valid_reg <= (state_next == ST_DRAIN);
      out_last_reg  <= (state_next == ST_DRAIN) && is_last_idx(out_idx_next);
    end
  end

  assign in_ready  = in_ready_reg;
  assign busy      = busy_reg;
  assign smm_load  = load_reg;
  assign smm_sel   = sel_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign wr_a      = in_valid && (state_reg == ST_LOAD_A);
  assign wr_b      = in_valid && (state_reg == ST_LOAD_B);
  assign wr_idx    = in_cnt_reg;
  assign out_idx   = out_idx_reg;
  assign capture   = (state_reg == ST_WAIT) && (wait_cnt_reg == WAIT_LAST);

endmodule

// File: rtl/smm1_sequencer.sv
// Streams two row-major 4x4 matrices into packed buses, pulses the multiplier
// and streams the captured product back out element by element.
module smm1_sequencer
  import smm_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int BUSWIDTH  = DATAWIDTH * 16,
  parameter int LATENCY   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 sel_in,
  output logic [BUSWIDTH-1:0]  smm_a,
  output logic [BUSWIDTH-1:0]  smm_b,
  output logic                 smm_load,
  output logic                 smm_sel,
  input  logic [BUSWIDTH-1:0]  smm_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  logic [DATAWIDTH-1:0] a_reg   [ELEMS];
  logic [DATAWIDTH-1:0] b_reg   [ELEMS];
  logic [DATAWIDTH-1:0] res_reg [ELEMS];
  logic                 wr_a, wr_b, capture;
  logic [IDX_W-1:0]     wr_idx, out_idx;

  smm1_sequencer_ctrl #(
    .LATENCY (LATENCY)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sel_in    (sel_in),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .busy      (busy),
    .smm_load  (smm_load),
    .smm_sel   (smm_sel),
    .out_valid (out_valid),
    .out_last  (out_last),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .wr_idx    (wr_idx),
    .out_idx   (out_idx),
    .capture   (capture)
  );

  // Operand and result storage; operands only change on accepted beats, so the
  // buses stay frozen from the load pulse until the product is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ELEMS; i++) begin
        a_reg[i]   <= '0;
        b_reg[i]   <= '0;
        res_reg[i] <= '0;
      end
    end else begin
      if (wr_a) a_reg[wr_idx] <= in_data;
      if (wr_b) b_reg[wr_idx] <= in_data;
      if (capture) begin
        for (int i = 0; i < ELEMS; i++) begin
          res_reg[i] <= smm_c[i*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_pack
      assign smm_a[gi*DATAWIDTH +: DATAWIDTH] = a_reg[gi];
      assign smm_b[gi*DATAWIDTH +: DATAWIDTH] = b_reg[gi];
    end
    if (BUSWIDTH > ELEMS * DATAWIDTH) begin : g_pad
      assign smm_a[BUSWIDTH-1:ELEMS*DATAWIDTH] = '0;
      assign smm_b[BUSWIDTH-1:ELEMS*DATAWIDTH] = '0;
    end
  endgenerate

  assign out_data = res_reg[out_idx];

endmodule

// File: tb/tb_smm1_sequencer.sv
// Self-checking bench: table vectors, randomized transactions and reset abort,
// with a latency-accurate multiplier stub driving smm_c.
module tb_smm1_sequencer;

  localparam int DW  = 32;
  localparam int BW  = DW * 16;
  localparam int LAT = 12;

  typedef logic [DW-1:0] mat_t [16];

  typedef struct {
    logic [31:0] a0;
    logic [31:0] a_step;
    bit          b_ident;
    logic [31:0] b0;
    logic [31:0] b_step;
    bit          sel;
    int          mode;
    logic [15:0] stall;
    logic [31:0] e0;
    logic [31:0] e_step;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          sel_in = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, smm_load, smm_sel, out_valid, out_last, busy;
  logic [BW-1:0] smm_a, smm_b, smm_c;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  smm1_sequencer #(
    .DATAWIDTH (DW),
    .BUSWIDTH  (BW),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel_in    (sel_in),
    .smm_a     (smm_a),
    .smm_b     (smm_b),
    .smm_load  (smm_load),
    .smm_sel   (smm_sel),
    .smm_c     (smm_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Multiplier stub: product appears LAT cycles after the load pulse; before
  // that the bus carries the inverted product so an early capture shows up.
  int            stub_mode = 0;
  int            lat_cnt;
  logic [BW-1:0] snap_a, snap_b, prod;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= 0;
      snap_a  <= '0;
      snap_b  <= '0;
    end else if (smm_load) begin
      lat_cnt <= 1;
      snap_a  <= smm_a;
      snap_b  <= smm_b;
    end else if (lat_cnt > 0 && lat_cnt < LAT) begin
      lat_cnt <= lat_cnt + 1;
    end
  end

  always_comb begin
    case (stub_mode)
      0:       prod = snap_a;
      1:       prod = snap_b;
      default: prod = {BW{1'b1}};
    endcase
  end

  assign smm_c = (lat_cnt >= LAT) ? prod : ~prod;

  // Event monitor, sampled mid-cycle.
  int   cyc = 0, beats = 0, loads = 0, load_cyc = 0, valid_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_valid <= out_valid;
    if (in_valid && in_ready) beats <= beats + 1;
    if (smm_load) begin
      loads    <= loads + 1;
      load_cyc <= cyc;
    end
    if (out_valid && !prev_valid) valid_cyc <= cyc;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output bit ok);
    bit rdy;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      rdy = in_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input mat_t a, input mat_t b, input bit sel, input int mode,
                         input logic [15:0] stall, input int gap_max, input mat_t e,
                         input string tag);
    int  b0, l0, f0;
    bit  ok;
    stub_mode = mode;
    b0 = beats;
    l0 = loads;
    f0 = n_checks - n_pass;
    for (int i = 0; i < 32; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) step();
      end
      in_valid = 1'b1;
      in_data  = (i < 16) ? a[i] : b[i-16];
      sel_in   = (i == 0) ? sel : ~sel;
      wait_accept(ok);
      if (!ok) begin
        check("accept_timeout", 64'(i), 64'd32);
        break;
      end
      if (i == 0) check("sel_capture", 64'(smm_sel), 64'(sel));
    end
    // keep offering junk: nothing may be accepted until the drain completes
    in_data = 32'hBAD0_BAD0;
    sel_in  = ~sel;
    check("fire_load", 64'(smm_load), 64'd1);
    check("fire_in_ready", 64'(in_ready), 64'd0);
    step();
    check("wait_load_low", 64'(smm_load), 64'd0);
    check("wait_busy", 64'(busy), 64'd1);
    ok = 1'b0;
    for (int t = 0; t < LAT + 20; t++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("drain_start", 64'(ok), 64'd1);
    check("a_stable", 64'(smm_a === snap_a), 64'd1);
    for (int i = 0; i < 16; i++) begin
      if (stall[i]) begin
        out_ready = 1'b0;
        repeat (2) begin
          step();
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(e[i]));
          check("stall_last", 64'(out_last), 64'(i == 15));
        end
      end
      out_ready = 1'b1;
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_data", 64'(out_data), 64'(e[i]));
      check("out_last", 64'(out_last), 64'(i == 15));
      check("drain_sel", 64'(smm_sel), 64'(sel));
      check("drain_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("end_valid", 64'(out_valid), 64'd0);
    check("end_in_ready", 64'(in_ready), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("beat_count", 64'(beats - b0), 64'd32);
    check("load_count", 64'(loads - l0), 64'd1);
    check("latency", 64'(valid_cyc - load_cyc), 64'(LAT + 1));
    $display("txn %s mode=%0d sel=%0d stall=%04h new_errors=%0d", tag, mode, sel, stall,
             (n_checks - n_pass) - f0);
  endtask

  initial begin
    vec_t        vecs [5];
    mat_t        a, b, e;
    int          mode, l0;
    bit          sel, ok;
    logic [15:0] stall;

    vecs[0] = '{32'd1, 32'd1, 1'b1, 32'd0, 32'd0, 1'b0, 0, 16'h0000, 32'd1, 32'd1};
    vecs[1] = '{32'hFFFF_FFF8, 32'd1, 1'b1, 32'd0, 32'd0, 1'b1, 0, 16'h0002,
                32'hFFFF_FFF8, 32'd1};
    vecs[2] = '{32'd5, 32'd7, 1'b0, 32'd100, 32'd3, 1'b1, 1, 16'h8001, 32'd100, 32'd3};
    vecs[3] = '{32'd0, 32'd0, 1'b0, 32'd9, 32'd0, 1'b0, 2, 16'hA5A5,
                32'hFFFF_FFFF, 32'd0};
    vecs[4] = '{32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFF0, 32'd1, 1'b0, 0, 16'hFFFF,
                32'h8000_0000, 32'd1};

    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_load", 64'(smm_load), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sel", 64'(smm_sel), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) begin
        a[i] = vecs[v].a0 + vecs[v].a_step * 32'(i);
        b[i] = vecs[v].b_ident ? 32'(i % 5 == 0) : vecs[v].b0 + vecs[v].b_step * 32'(i);
        e[i] = vecs[v].e0 + vecs[v].e_step * 32'(i);
      end
      run_txn(a, b, vecs[v].sel, vecs[v].mode, vecs[v].stall, 0, e, "table");
    end

    // Reset after 20 beats: partial load discarded, no load pulse.
    l0 = loads;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      sel_in   = (i == 0);
      wait_accept(ok);
    end
    in_valid = 1'b0;
    check("partial_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_load", 64'(smm_load), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sel", 64'(smm_sel), 64'd0);
    check("abort_a_zero", 64'(|smm_a), 64'd0);
    check("abort_b_zero", 64'(|smm_b), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    step();
    rst = 1'b0;
    repeat (LAT + 5) step();
    check("abort_no_load", 64'(loads - l0), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 16; i++) begin
      a[i] = 32'(i + 1);
      b[i] = 32'(i % 5 == 0);
      e[i] = 32'(i + 1);
    end
    run_txn(a, b, 1'b0, 0, 16'h0000, 0, e, "post_reset");

    // Randomized transactions against a whole-matrix reference model.
    for (int n = 0; n < 12; n++) begin
      mode  = int'($urandom_range(2, 0));
      sel   = 1'($urandom_range(1, 0));
      stall = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        a[i] = $urandom;
        b[i] = $urandom;
      end
      for (int i = 0; i < 16; i++) begin
        e[i] = (mode == 0) ? a[i] : (mode == 1) ? b[i] : '1;
      end
      run_txn(a, b, sel, mode, stall, 3, e, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
